sd_cmd_engine: RTL and testbench

SD-bus command-line engine that consumes the fields programmed into the host Command register and drives the card side of the CMD protocol. On a start pulse it serializes a 48-bit command frame with CRC7. It then receives and checks the card response selected by the response-type field, and optionally waits out DAT0 busy. It sits between the register set and the CMD/DAT0 pads and runs in the card-clock domain at one bit per clk cycle.

---
 rtl/sd_cmd_engine.sv | 202 ++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serializes a 48-bit command with CRC7, receives and checks
// the selected response, and optionally waits for DAT0 busy to be released.
module sd_cmd_engine #(
  parameter int RESP_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         idx_chk_en,
  input  logic         crc_chk_en,
  input  logic         data_present,
  input  logic         cmd_in,
  input  logic         dat0_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [119:0] resp,
  output logic         err_timeout,
  output logic         err_crc,
  output logic         err_index,
  output logic         err_end,
  output logic         data_start
);
  localparam int MaxTimeout = (BUSY_TIMEOUT > RESP_TIMEOUT) ? BUSY_TIMEOUT : RESP_TIMEOUT;
  localparam int TimerW = $clog2(MaxTimeout + 1);
  localparam logic [TimerW-1:0] respLast = TimerW'(RESP_TIMEOUT - 1);
  localparam logic [TimerW-1:0] busyLast = TimerW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, TX, WAIT, RX, BUSYW, DONE} stateType;

  function automatic logic [6:0] crcStep(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc40(input logic [39:0] d);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) crc = crcStep(crc, d[i]);
    return crc;
  endfunction

  function automatic logic [6:0] crc120(input logic [119:0] d);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 119; i >= 0; i--) crc = crcStep(crc, d[i]);
    return crc;
  endfunction

  // Payload placement: R2 carries 120 bits, 48-bit responses carry 32.
  function automatic logic [119:0] respOf(input logic [135:0] f, input logic r2);
    return r2 ? f[127:8] : {88'd0, f[39:8]};
  endfunction

  stateType          state;
  logic [46:0]       txShift;
  logic [5:0]        txCnt;
  logic [135:0]      rxShift;
  logic [7:0]        rxCnt;
  logic [TimerW-1:0] timer;
  logic [5:0]        idxQ;
  logic [1:0]        typeQ;
  logic              idxChkQ, crcChkQ, dataQ;

  logic [39:0]  txHead;
  logic [47:0]  txFrame;
  logic [135:0] rxFull;
  logic         isR2, rxLast, crcBad, idxBad;
  logic         newErrCrc, newErrIdx, newErrEnd;

  assign txHead  = {2'b01, cmd_index, cmd_arg};
  assign txFrame = {txHead, crc40(txHead), 1'b1};

  // rxFull includes the bit being sampled this cycle, so checks resolve on the last bit.
  assign rxFull    = {rxShift[134:0], cmd_in};
  assign isR2      = (typeQ == 2'b01);
  assign rxLast    = isR2 ? (rxCnt == 8'd135) : (rxCnt == 8'd47);
  assign crcBad    = isR2 ? (crc120(rxFull[127:8]) != rxFull[7:1])
                          : (crc40(rxFull[47:8]) != rxFull[7:1]);
  assign idxBad    = !isR2 && (rxFull[45:40] != idxQ);
  assign newErrCrc = crcChkQ && crcBad;
  assign newErrIdx = idxChkQ && idxBad;
  assign newErrEnd = !rxFull[0];

  // NOTE: every output is a flop on the async reset, so rst releases cmd_oe mid-frame without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_start  <= 1'b0;
      resp        <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_index   <= 1'b0;
      err_end     <= 1'b0;
      txShift     <= '0;
      txCnt       <= '0;
      rxShift     <= '0;
      rxCnt       <= '0;
      timer       <= '0;
      idxQ        <= '0;
      typeQ       <= '0;
      idxChkQ     <= 1'b0;
      crcChkQ     <= 1'b0;
      dataQ       <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_start <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idxQ        <= cmd_index;
          typeQ       <= resp_type;
          idxChkQ     <= idx_chk_en;
          crcChkQ     <= crc_chk_en;
          dataQ       <= data_present;
          cmd_out     <= txFrame[47];
          txShift     <= txFrame[46:0];
          txCnt       <= 6'd47;
          cmd_oe      <= 1'b1;
          busy        <= 1'b1;
          err_timeout <= 1'b0;
          err_crc     <= 1'b0;
          err_index   <= 1'b0;
          err_end     <= 1'b0;
          state       <= TX;
        end
        TX: if (txCnt == 6'd0) begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          timer   <= '0;
          if (typeQ == 2'b00) begin
            done       <= 1'b1;
            data_start <= dataQ;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end else begin
          cmd_out <= txShift[46];
          txShift <= {txShift[45:0], 1'b0};
          txCnt   <= txCnt - 6'd1;
        end
        WAIT: if (!cmd_in) begin
          rxShift <= {rxShift[134:0], 1'b0};
          rxCnt   <= 8'd1;
          state   <= RX;
        end else if (timer == respLast) begin
          err_timeout <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end else begin
          timer <= timer + 1'b1;
        end
        RX: begin
          rxShift <= rxFull;
          rxCnt   <= rxCnt + 8'd1;
          if (rxLast) begin
            err_crc   <= newErrCrc;
            err_index <= newErrIdx;
            err_end   <= newErrEnd;
            timer     <= '0;
            if (typeQ == 2'b11) begin
              state <= BUSYW;
            end else begin
              resp       <= respOf(rxFull, isR2);
              done       <= 1'b1;
              data_start <= dataQ && !(newErrCrc || newErrIdx || newErrEnd);
              state      <= DONE;
            end
          end
        end
        BUSYW: if (dat0_in) begin
          resp       <= respOf(rxShift, 1'b0);
          done       <= 1'b1;
          data_start <= dataQ && !(err_crc || err_index || err_end);
          state      <= DONE;
        end else if (timer == busyLast) begin
          resp        <= respOf(rxShift, 1'b0);
          err_timeout <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end else begin
          timer <= timer + 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: a scoreboard queue holds the expected completion
// of each command and a negedge monitor compares it when done pulses.
module tb_sd_cmd_engine;
  logic         clk = 1'b0;
  logic         rst, start, idx_chk_en, crc_chk_en, data_present, cmd_in, dat0_in;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_out, cmd_oe, busy, done, data_start;
  logic         err_timeout, err_crc, err_index, err_end;
  logic [119:0] resp;

  always #5 clk = ~clk;

  sd_cmd_engine #(.RESP_TIMEOUT(64), .BUSY_TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_type(resp_type), .idx_chk_en(idx_chk_en), .crc_chk_en(crc_chk_en),
    .data_present(data_present), .cmd_in(cmd_in), .dat0_in(dat0_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .busy(busy), .done(done), .resp(resp),
    .err_timeout(err_timeout), .err_crc(err_crc), .err_index(err_index),
    .err_end(err_end), .data_start(data_start)
  );

  typedef struct {
    logic [119:0] resp;
    logic [3:0]   err;
    logic         ds;
    int           cyc;
  } expT;

  expT sb[$];
  expT mon;
  int  nTests = 0;
  int  nFail  = 0;
  int  cyc    = 0;
  int  c0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 as polynomial long division of d(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7Model(input logic [119:0] d, input int n);
    logic [126:0] r;
    r = {7'd0, d} << 7;
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame48(input logic [1:0] head, input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] h;
    h = {head, idx, arg};
    return {h, crc7Model(120'(h), 40), 1'b1};
  endfunction

  // Completion monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      check("sb_nonempty", 136'(sb.size() != 0), 136'(1));
      if (sb.size() != 0) begin
        mon = sb.pop_front();
        check("done_cycle", 136'(cyc - c0), 136'(mon.cyc - c0));
        check("resp", 136'(resp), 136'(mon.resp));
        check("err_flags", 136'({err_timeout, err_crc, err_index, err_end}), 136'(mon.err));
        check("data_start", 136'(data_start), 136'(mon.ds));
      end
    end
  end

  task automatic sendCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic ic, input logic cc, input logic dp,
                         input logic [47:0] expFrame, input logic [119:0] eResp,
                         input logic [3:0] eErr, input logic eDs, input int rel);
    logic [47:0] got;
    logic        oeOk;
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = rt;
    idx_chk_en = ic; crc_chk_en = cc; data_present = dp;
    start = 1'b1;
    c0 = cyc;
    sb.push_back('{resp: eResp, err: eErr, ds: eDs, cyc: c0 + rel});
    @(negedge clk);
    start = 1'b0;
    cmd_index = ~idx; cmd_arg = ~arg; resp_type = ~rt;
    idx_chk_en = ~ic; crc_chk_en = ~cc; data_present = ~dp;
    check("busy_rise", 136'(busy), 136'(1));
    oeOk = 1'b1;
    got  = '0;
    for (int k = 1; k <= 48; k++) begin
      if (k > 1) @(negedge clk);
      got[48-k] = cmd_out;
      oeOk = oeOk & (cmd_oe === 1'b1);
    end
    check("tx_frame", 136'(got), 136'(expFrame));
    check("tx_oe", 136'(oeOk), 136'(1));
    @(negedge clk);
    check("tx_release", 136'({cmd_oe, cmd_out}), 136'(2'b01));
  endtask

  // Card drives bits[len-1:0]; the start bit lands in cycle 48+delay (delay >= 2).
  task automatic respond(input logic [135:0] bits, input int len, input int delay, input logic pulse);
    repeat (delay - 2) begin
      @(negedge clk);
      start = pulse;
    end
    for (int j = len - 1; j >= 0; j--) begin
      @(negedge clk);
      cmd_in = bits[j];
      start  = pulse && (j == 20);
    end
  endtask

  task automatic waitDone(input int budget, input logic pulse);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      cmd_in = 1'b1;
      n++;
    end
    check("done_seen", 136'(done), 136'(1));
    start = pulse;
    @(negedge clk);
    start = 1'b0;
    check("busy_fall", 136'({busy, cmd_oe}), 136'(2'b00));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]  r48;
    logic [135:0] r2;
    logic [119:0] pay;
    logic         crcDiff;

    rst = 1'b1; start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
    idx_chk_en = 1'b0; crc_chk_en = 1'b0; data_present = 1'b0; cmd_in = 1'b1; dat0_in = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", 136'({cmd_out, cmd_oe, busy, done, data_start,
                              err_timeout, err_crc, err_index, err_end}), 136'(9'b1_0000_0000));
    check("reset_resp", 136'(resp), 136'(0));
    rst = 1'b0;

    // Reset in the middle of a CMD0 frame
    @(negedge clk);
    cmd_index = 6'd0; cmd_arg = '0; resp_type = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset_oe", 136'(cmd_oe), 136'(1));
    rst = 1'b1;
    #1;
    check("rst_midframe", 136'({cmd_oe, cmd_out, busy}), 136'(3'b010));
    @(negedge clk);
    rst = 1'b0;

    // CMD0, no response
    sendCmd(6'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 48'h400000000095, 120'd0, 4'b0000, 1'b0, 49);
    waitDone(10, 1'b0);

    // CMD8 with a clean R7-style response 5 cycles after the command
    sendCmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, 120'h1AA, 4'b0000, 1'b0, 101);
    respond(136'(48'h08000001AA13), 48, 5, 1'b0);
    waitDone(10, 1'b0);
    sendCmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 120'h1AA, 4'b0000, 1'b1, 101);
    respond(136'(48'h08000001AA13), 48, 5, 1'b0);
    waitDone(10, 1'b0);

    // Wrong index and inverted CRC bits, end bit kept at 1
    r48 = {2'b00, 6'd9, 32'h1AA, 7'h76, 1'b1};
    crcDiff = (crc7Model(120'({2'b00, 6'd9, 32'h1AA}), 40) != 7'h76);
    sendCmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 120'h1AA,
            {1'b0, crcDiff, 1'b1, 1'b0}, 1'b0, 101);
    respond(136'(r48), 48, 5, 1'b0);
    waitDone(10, 1'b0);
    sendCmd(6'd8, 32'h1AA, 2'b10, 1'b0, 1'b0, 1'b1, 48'h48000001AA87, 120'h1AA, 4'b0000, 1'b1, 101);
    respond(136'(r48), 48, 5, 1'b0);
    waitDone(10, 1'b0);

    // No start bit: timeout, resp keeps the previous payload
    sendCmd(6'd17, 32'h0000_0200, 2'b10, 1'b1, 1'b1, 1'b1, frame48(2'b01, 6'd17, 32'h0000_0200),
            120'h1AA, 4'b1000, 1'b0, 113);
    waitDone(100, 1'b0);

    // R1b: DAT0 low for 100 cycles after the response, with start pulses that must be ignored
    dat0_in = 1'b0;
    sendCmd(6'd7, 32'h0001_0000, 2'b11, 1'b1, 1'b1, 1'b0, frame48(2'b01, 6'd7, 32'h0001_0000),
            120'h700, 4'b0000, 1'b0, 200);
    respond(136'(frame48(2'b00, 6'd7, 32'h0000_0700)), 48, 3, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmd_in = 1'b1;
      start  = (i == 50);
    end
    @(negedge clk);
    start   = 1'b0;
    dat0_in = 1'b1;
    waitDone(10, 1'b0);

    // R2 with a known payload; start pulsed during RX and in the done cycle
    pay = 120'h112233445566778899AABBCCDDEEFF;
    r2  = {2'b00, 6'h3F, pay, crc7Model(pay, 120), 1'b1};
    sendCmd(6'd2, 32'd0, 2'b01, 1'b1, 1'b1, 1'b1, frame48(2'b01, 6'd2, 32'd0),
            pay, 4'b0000, 1'b1, 186);
    respond(r2, 136, 2, 1'b1);
    waitDone(10, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drained", 136'(sb.size()), 136'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
